// File: rtl/evm_pkg.sv
// Shared constants for the EVM result display: segment codes and digit-index encoding.
// Segment codes are active-low {g,f,e,d,c,b,a}.
package evm_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'h3F;

  // Index 3 is the leftmost digit; scanning runs 3 -> 2 -> 1 -> 0 -> 3.
  typedef enum logic [1:0] {
    DIG_ONES = 2'd0,
    DIG_TENS = 2'd1,
    DIG_HUND = 2'd2,
    DIG_CAND = 2'd3
  } dig_e;

  // Entry [n] is the code for decimal digit n.
  localparam logic [9:0][6:0] SEG_TABLE = {
    7'h10, 7'h00, 7'h78, 7'h02, 7'h12,
    7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

  typedef struct packed {
    logic       inv;
    logic [3:0] x1;
    logic [3:0] y1;
    logic [3:0] z1;
    logic [3:0] x2;
    logic [3:0] y2;
    logic [3:0] z2;
  } snap_t;

endpackage

// File: rtl/bcd_to_seg.sv
// BCD digit to active-low seven-segment code; values above 9 decode to a dash.
// Purely combinational.
module bcd_to_seg
  import evm_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_DASH;
    if (bcd <= 4'd9) seg = SEG_TABLE[bcd];
  end

endmodule

// File: rtl/evm_result_display.sv
// Multiplexed 4-digit result display alternating "1XYZ" / "2XYZ" pages, with inputs snapshotted per frame.
// Optional LEAD_ZERO_BLANK_EN blanks leading zeros of the count.
module evm_result_display
  import evm_pkg::*;
#(
  parameter int SCAN_DIV    = 50000,
  parameter int PAGE_FRAMES = 400
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [3:0] X1,
  input  logic [3:0] Y1,
  input  logic [3:0] Z1,
  input  logic [3:0] X2,
  input  logic [3:0] Y2,
  input  logic [3:0] Z2,
  input  logic       invalid,
  output logic [6:0] seg,
  output logic [3:0] an,
  output logic       dp,
  output logic       page
);

  localparam int SW = $clog2(SCAN_DIV);
  localparam int FW = $clog2(PAGE_FRAMES + 1);
  localparam logic [SW-1:0] SCAN_LAST  = SW'(SCAN_DIV - 1);
  localparam logic [FW-1:0] FRAME_LAST = FW'(PAGE_FRAMES - 1);

  logic [SW-1:0] scan_cnt, scan_cnt_nxt;
  dig_e          idx, idx_nxt;
  logic [FW-1:0] frame_cnt, frame_cnt_nxt;
  logic          page_q, page_nxt;
  snap_t         snap, snap_nxt;

  logic [3:0] cand_x, cand_y, cand_z, dig;
  logic [6:0] dig_seg, seg_nxt;
  logic [3:0] an_nxt;
  logic       blank;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      scan_cnt  <= '0;
      idx       <= DIG_CAND;
      frame_cnt <= '0;
      page_q    <= 1'b0;
      snap      <= '0;
      seg       <= SEG_BLANK;
      an        <= 4'b1111;
    end else begin
      scan_cnt  <= scan_cnt_nxt;
      idx       <= idx_nxt;
      frame_cnt <= frame_cnt_nxt;
      page_q    <= page_nxt;
      snap      <= snap_nxt;
      seg       <= seg_nxt;
      an        <= an_nxt;
    end
  end

  // Snapshot and page flip both happen on the 0 -> 3 index wrap (frame boundary).
  always_comb begin
    scan_cnt_nxt  = scan_cnt + 1'b1;
    idx_nxt       = idx;
    frame_cnt_nxt = frame_cnt;
    page_nxt      = page_q;
    snap_nxt      = snap;
    if (scan_cnt == SCAN_LAST) begin
      scan_cnt_nxt = '0;
      idx_nxt      = dig_e'(idx - 2'd1);
      if (idx == DIG_ONES) begin
        snap_nxt = '{inv: invalid, x1: X1, y1: Y1, z1: Z1, x2: X2, y2: Y2, z2: Z2};
        if (frame_cnt == FRAME_LAST) begin
          frame_cnt_nxt = '0;
          page_nxt      = ~page_q;
        end else begin
          frame_cnt_nxt = frame_cnt + 1'b1;
        end
      end
    end
  end

  // Outputs are decoded from next-state so seg and an track idx on the same edge.
  always_comb begin
    cand_x = page_nxt ? snap_nxt.x2 : snap_nxt.x1;
    cand_y = page_nxt ? snap_nxt.y2 : snap_nxt.y1;
    cand_z = page_nxt ? snap_nxt.z2 : snap_nxt.z1;
    dig    = cand_z;
    case (idx_nxt)
      DIG_CAND: dig = page_nxt ? 4'd2 : 4'd1;
      DIG_HUND: dig = cand_x;
      DIG_TENS: dig = cand_y;
      default:  dig = cand_z;
    endcase
`ifdef LEAD_ZERO_BLANK_EN
    blank = ((idx_nxt == DIG_HUND) && (cand_x == 4'd0)) ||
            ((idx_nxt == DIG_TENS) && (cand_x == 4'd0) && (cand_y == 4'd0));
`else
    blank = 1'b0;
`endif
  end

  bcd_to_seg u_dec (
    .bcd (dig),
    .seg (dig_seg)
  );

  always_comb begin
    an_nxt          = 4'b1111;
    an_nxt[idx_nxt] = 1'b0;
    seg_nxt         = dig_seg;
    if (blank) seg_nxt = SEG_BLANK;
    if (snap_nxt.inv) seg_nxt = SEG_DASH;
  end

  assign page = page_q;
  assign dp   = 1'b1;

endmodule

// File: tb/tb_evm_result_display.sv
// Self-checking bench for evm_result_display: table-driven pages, hand-written corner sequences,
// and randomized inputs compared against a frame/page reference model.
module tb_evm_result_display;

  localparam int SD    = 4;
  localparam int PF    = 2;
  localparam int FRAME = 4 * SD;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [3:0] X1 = '0, Y1 = '0, Z1 = '0, X2 = '0, Y2 = '0, Z2 = '0;
  logic       invalid = 1'b0;
  logic [6:0] seg;
  logic [3:0] an;
  logic       dp;
  logic       page;

  int checks = 0;
  int errors = 0;

  // Reference model state: edges since reset release and the last frame snapshot.
  int         k = 0;
  logic [3:0] m_x1, m_y1, m_z1, m_x2, m_y2, m_z2;
  logic       m_inv;

  evm_result_display #(.SCAN_DIV(SD), .PAGE_FRAMES(PF)) dut (
    .clk(clk), .reset_n(reset_n),
    .X1(X1), .Y1(Y1), .Z1(Z1), .X2(X2), .Y2(Y2), .Z2(Z2),
    .invalid(invalid), .seg(seg), .an(an), .dp(dp), .page(page)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] enc(input logic [3:0] d);
    case (d)
      4'd0: enc = 7'h40; 4'd1: enc = 7'h79; 4'd2: enc = 7'h24; 4'd3: enc = 7'h30;
      4'd4: enc = 7'h19; 4'd5: enc = 7'h12; 4'd6: enc = 7'h02; 4'd7: enc = 7'h78;
      4'd8: enc = 7'h00; 4'd9: enc = 7'h10;
      default: enc = 7'h3F;
    endcase
  endfunction

  task automatic expect_eq(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at k=%0d: got %h, expected %h", name, k, act, exp);
    end
  endtask

  task automatic model_check();
    logic [3:0] ea, x, y, z;
    logic [6:0] es;
    logic       pg;
    int         di;
    ea = 4'hF; es = 7'h7F; pg = 1'b0;
    if (k > 0) begin
      di = 3 - ((k / SD) % 4);
      pg = ((k / (FRAME * PF)) % 2) == 1;
      ea[di] = 1'b0;
      x = pg ? m_x2 : m_x1;
      y = pg ? m_y2 : m_y1;
      z = pg ? m_z2 : m_z1;
      case (di)
        3: es = enc(pg ? 4'd2 : 4'd1);
        2: es = enc(x);
        1: es = enc(y);
        default: es = enc(z);
      endcase
`ifdef LEAD_ZERO_BLANK_EN
      if ((di == 2 && x == 0) || (di == 1 && x == 0 && y == 0)) es = 7'h7F;
`endif
      if (m_inv) es = 7'h3F;
    end
    expect_eq("model {page,dp,an,seg}", {3'b0, page, dp, an, seg}, {3'b0, pg, 1'b1, ea, es});
  endtask

  task automatic tick();
    @(posedge clk);
    if (reset_n) begin
      k++;
      if (k % FRAME == 0) begin
        m_x1 = X1; m_y1 = Y1; m_z1 = Z1;
        m_x2 = X2; m_y2 = Y2; m_z2 = Z2;
        m_inv = invalid;
      end
    end
    @(negedge clk);
    model_check();
  endtask

  task automatic run_to(input int target);
    while (k < target) tick();
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    k = 0;
    {m_x1, m_y1, m_z1, m_x2, m_y2, m_z2} = '0;
    m_inv = 1'b0;
    #1;
    expect_eq("reset {page,dp,an,seg}", {3'b0, page, dp, an, seg}, {3'b0, 1'b0, 1'b1, 4'hF, 7'h7F});
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  function automatic logic [3:0] rnd_digit();
    int r;
    r = $urandom_range(0, 9);
    if (r < 2) return 4'd0;
    if (r == 9) return 4'($urandom_range(10, 15));
    return 4'($urandom_range(1, 9));
  endfunction

  typedef struct packed {
    logic [3:0]      x1, y1, z1, x2, y2, z2;
    logic            inv;
    logic [3:0][6:0] e0;  // page 0 codes, [3] = leftmost digit
    logic [3:0][6:0] e1;  // page 1 codes
  } vec_t;

  vec_t vecs [5];

  initial begin
    vecs[0] = '{4'd1, 4'd2, 4'd5, 4'd0, 4'd4, 4'd7, 1'b0,
`ifdef LEAD_ZERO_BLANK_EN
                {7'h79, 7'h79, 7'h24, 7'h12}, {7'h24, 7'h7F, 7'h19, 7'h78}};
`else
                {7'h79, 7'h79, 7'h24, 7'h12}, {7'h24, 7'h40, 7'h19, 7'h78}};
`endif
    vecs[1] = '{4'd3, 4'd1, 4'd4, 4'd1, 4'd5, 4'd9, 1'b1,
                {7'h3F, 7'h3F, 7'h3F, 7'h3F}, {7'h3F, 7'h3F, 7'h3F, 7'h3F}};
    vecs[2] = '{4'hB, 4'd3, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0,
`ifdef LEAD_ZERO_BLANK_EN
                {7'h79, 7'h3F, 7'h30, 7'h40}, {7'h24, 7'h7F, 7'h7F, 7'h40}};
`else
                {7'h79, 7'h3F, 7'h30, 7'h40}, {7'h24, 7'h40, 7'h40, 7'h40}};
`endif
    vecs[3] = '{4'd9, 4'd8, 4'd7, 4'd6, 4'd5, 4'd4, 1'b0,
                {7'h79, 7'h10, 7'h00, 7'h78}, {7'h24, 7'h02, 7'h12, 7'h19}};
    vecs[4] = '{4'd0, 4'd0, 4'd9, 4'd0, 4'd5, 4'd0, 1'b0,
`ifdef LEAD_ZERO_BLANK_EN
                {7'h79, 7'h7F, 7'h7F, 7'h10}, {7'h24, 7'h7F, 7'h12, 7'h40}};
`else
                {7'h79, 7'h40, 7'h40, 7'h10}, {7'h24, 7'h40, 7'h12, 7'h40}};
`endif

    // Table: one page-0 frame then one page-1 frame per vector.
    for (int v = 0; v < 5; v++) begin
      do_reset();
      X1 = vecs[v].x1; Y1 = vecs[v].y1; Z1 = vecs[v].z1;
      X2 = vecs[v].x2; Y2 = vecs[v].y2; Z2 = vecs[v].z2;
      invalid = vecs[v].inv;
      run_to(FRAME - 1);
      for (int c = FRAME; c < 3 * FRAME; c++) begin
        int di;
        tick();
        di = 3 - ((k / SD) % 4);
        if (k < 2 * FRAME) expect_eq("table page0 seg", {9'b0, seg}, {9'b0, vecs[v].e0[di]});
        else               expect_eq("table page1 seg", {9'b0, seg}, {9'b0, vecs[v].e1[di]});
      end
      invalid = 1'b0;
    end

    // Mid-frame change is held until the next page-0 frame boundary.
    do_reset();
    X1 = 4'd1; Y1 = 4'd2; Z1 = 4'd5; X2 = 4'd0; Y2 = 4'd4; Z2 = 4'd7;
    run_to(20);
    Z1 = 4'd6;
    run_to(31);
    expect_eq("held ones digit", {5'b0, an, seg}, {5'b0, 4'b1110, 7'h12});
    run_to(79);
    expect_eq("updated ones digit", {5'b0, an, seg}, {5'b0, 4'b1110, 7'h02});

    // Invalid takes effect only at the following frame boundary, then clears.
    run_to(81);
    invalid = 1'b1;
    run_to(95);
    expect_eq("invalid not yet seen", {5'b0, an, seg}, {5'b0, 4'b1110, 7'h02});
    run_to(100);
    expect_eq("invalid dash", {9'b0, seg}, {9'b0, 7'h3F});
    invalid = 1'b0;
    run_to(112);
    expect_eq("invalid cleared", {4'b0, page, an, seg}, {4'b0, 1'b1, 4'b0111, 7'h24});

    // Asynchronous reset mid-digit blanks without waiting for a clock edge.
    run_to(114);
    #2;
    reset_n = 1'b0;
    k = 0;
    {m_x1, m_y1, m_z1, m_x2, m_y2, m_z2} = '0;
    m_inv = 1'b0;
    #1;
    expect_eq("async reset", {3'b0, page, dp, an, seg}, {3'b0, 1'b0, 1'b1, 4'hF, 7'h7F});
    @(negedge clk);
    reset_n = 1'b1;

    // Randomized inputs against the reference model, with occasional resets.
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 5) == 0) begin
        X1 = rnd_digit(); Y1 = rnd_digit(); Z1 = rnd_digit();
        X2 = rnd_digit(); Y2 = rnd_digit(); Z2 = rnd_digit();
        invalid = ($urandom_range(0, 7) == 0);
      end
      if ($urandom_range(0, 499) == 0) do_reset();
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
